cpu_boot_sequencer: RTL and testbench

Parametrised boot and run controller that sits between the bench/host and `system_cpu_master`. It holds the CPU in reset, streams a program image into instruction memory over a valid/ready port, and releases CPU reset after a programmable hold. It then supervises execution until the CPU signals halt, or until a watchdog expires, and captures the data-memory word on `data_mem_to_cpu` as the run result.

---
 rtl/cpu_boot_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_cpu_boot_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_boot_sequencer.sv
// Boot/run controller: holds the CPU in reset, streams a program image into
// instruction memory, releases reset after a hold, then supervises the run.
module cpu_boot_sequencer #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int PROG_DEPTH = 256,
    parameter int RST_HOLD   = 4,
    parameter int WDT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_rst,
    input  logic              cpu_halt,
    input  logic [DATA_W-1:0] data_mem_to_cpu,
    output logic [ADDR_W:0]   word_count,
    output logic [DATA_W-1:0] result,
    output logic              run_done,
    output logic              timeout
);

    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam int WDT_W  = $clog2(WDT_CYCLES);

    localparam logic [ADDR_W:0]   DEPTH_C     = (ADDR_W + 1)'(PROG_DEPTH);
    localparam logic [ADDR_W:0]   WC_ONE_C    = (ADDR_W + 1)'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST_C = HOLD_W'(RST_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE_C  = HOLD_W'(1);
    // Expiry is detected one count early so timeout lands on edge R+WDT_CYCLES-1.
    localparam logic [WDT_W-1:0]  WDT_LAST_C  = WDT_W'(WDT_CYCLES - 2);
    localparam logic [WDT_W-1:0]  WDT_ONE_C   = WDT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_HOLD    = 3'd2,
        ST_RUN     = 3'd3,
        ST_DONE    = 3'd4,
        ST_TIMEOUT = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W:0]    word_count_q, word_count_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [WDT_W-1:0]   wdt_q, wdt_d;
    logic               cpu_rst_q, cpu_rst_d;
    logic               imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
    logic [DATA_W-1:0]  imem_wdata_q, imem_wdata_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               run_done_q, run_done_d;
    logic               timeout_q, timeout_d;

    logic               load_ready_s;
    logic               handshake_s;
    logic [ADDR_W:0]    word_inc_s;

    assign load_ready_s = (state_q == ST_LOAD) && (word_count_q < DEPTH_C);
    assign handshake_s  = load_valid & load_ready_s;
    assign word_inc_s   = word_count_q + WC_ONE_C;

    // Next-state and next-output decode for the boot/run FSM.
    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        hold_cnt_d   = hold_cnt_q;
        wdt_d        = wdt_q;
        cpu_rst_d    = cpu_rst_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        result_d     = result_q;
        run_done_d   = run_done_q;
        timeout_d    = timeout_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                cpu_rst_d = 1'b1;
                if (start) begin
                    state_d      = ST_LOAD;
                    word_count_d = {(ADDR_W + 1){1'b0}};
                    result_d     = {DATA_W{1'b0}};
                    run_done_d   = 1'b0;
                    timeout_d    = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                cpu_rst_d = 1'b1;
                if (handshake_s) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = word_count_q[ADDR_W-1:0];
                    imem_wdata_d = load_data;
                    word_count_d = word_inc_s;
                    if (load_last || (word_inc_s == DEPTH_C)) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = {HOLD_W{1'b0}};
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    imem_we_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST_C) begin
                    state_d   = ST_RUN;
                    wdt_d     = {WDT_W{1'b0}};
                    cpu_rst_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_ONE_C;
                    cpu_rst_d  = 1'b1;
                end
            end
            ST_RUN: begin
                // Halt is tested first so it wins over a coincident expiry.
                if (cpu_halt) begin
                    state_d    = ST_DONE;
                    result_d   = data_mem_to_cpu;
                    run_done_d = 1'b1;
                    cpu_rst_d  = 1'b1;
                end else if (wdt_q == WDT_LAST_C) begin
                    state_d   = ST_TIMEOUT;
                    timeout_d = 1'b1;
                    cpu_rst_d = 1'b1;
                end else begin
                    wdt_d     = wdt_q + WDT_ONE_C;
                    cpu_rst_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cpu_rst_d = 1'b1;
            end
        endcase
    end

    // State and registered-output flops with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            word_count_q <= {(ADDR_W + 1){1'b0}};
            hold_cnt_q   <= {HOLD_W{1'b0}};
            wdt_q        <= {WDT_W{1'b0}};
            cpu_rst_q    <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= {ADDR_W{1'b0}};
            imem_wdata_q <= {DATA_W{1'b0}};
            result_q     <= {DATA_W{1'b0}};
            run_done_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            hold_cnt_q   <= hold_cnt_d;
            wdt_q        <= wdt_d;
            cpu_rst_q    <= cpu_rst_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            result_q     <= result_d;
            run_done_q   <= run_done_d;
            timeout_q    <= timeout_d;
        end
    end

    assign load_ready = load_ready_s;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign word_count = word_count_q;
    assign result     = result_q;
    assign run_done   = run_done_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_cpu_boot_sequencer.sv
// Directed bench: instance A uses default sizing, instance B a 4-word program
// depth and a 16-cycle watchdog. Both share stimulus; each test checks one.
module tb_cpu_boot_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_last;
    logic        cpu_halt;
    logic [15:0] data_mem;

    logic        a_ready, a_we, a_cpu_rst, a_done, a_to;
    logic [7:0]  a_addr;
    logic [15:0] a_wdata, a_result;
    logic [8:0]  a_wc;
    logic        b_ready, b_we, b_cpu_rst, b_done, b_to;
    logic [7:0]  b_addr;
    logic [15:0] b_wdata, b_result;
    logic [8:0]  b_wc;

    logic [53:0] a_vec, b_vec;
    logic [53:0] reset_vec;

    int tests_run;
    int tests_failed;

    assign a_vec = {a_cpu_rst, a_ready, a_we, a_addr, a_wdata, a_wc, a_result, a_done, a_to};
    assign b_vec = {b_cpu_rst, b_ready, b_we, b_addr, b_wdata, b_wc, b_result, b_done, b_to};

    cpu_boot_sequencer #(
        .DATA_W(16), .ADDR_W(8), .PROG_DEPTH(256), .RST_HOLD(4), .WDT_CYCLES(1024)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(a_ready), .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
        .cpu_rst(a_cpu_rst), .cpu_halt(cpu_halt), .data_mem_to_cpu(data_mem),
        .word_count(a_wc), .result(a_result), .run_done(a_done), .timeout(a_to)
    );

    cpu_boot_sequencer #(
        .DATA_W(16), .ADDR_W(8), .PROG_DEPTH(4), .RST_HOLD(4), .WDT_CYCLES(16)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(b_ready), .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
        .cpu_rst(b_cpu_rst), .cpu_halt(cpu_halt), .data_mem_to_cpu(data_mem),
        .word_count(b_wc), .result(b_result), .run_done(b_done), .timeout(b_to)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; load_valid = 1'b0; load_data = 16'h0;
        load_last = 1'b0; cpu_halt = 1'b0; data_mem = 16'h0;
        repeat (2) step();
        rst = 1'b1;
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Loads one word with load_last, then waits until RUN is entered (edge R).
    task automatic load_one_and_run(input logic [15:0] w);
        load_valid = 1'b1; load_data = w; load_last = 1'b1;
        step();
        load_valid = 1'b0; load_last = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; load_valid = 1'b0; load_data = 16'h0;
        load_last = 1'b0; cpu_halt = 1'b0; data_mem = 16'h0;
        repeat (3) step();
        tests_run++;
        if (a_vec !== reset_vec) begin
            tests_failed++;
            $display("FAIL reset_during_a: got %h expected %h", a_vec, reset_vec);
        end
        tests_run++;
        if (b_vec !== reset_vec) begin
            tests_failed++;
            $display("FAIL reset_during_b: got %h expected %h", b_vec, reset_vec);
        end
        rst = 1'b1;
        repeat (4) step();
        tests_run++;
        if (a_vec !== reset_vec) begin
            tests_failed++;
            $display("FAIL reset_idle_a: got %h expected %h", a_vec, reset_vec);
        end
    endtask

    task automatic test_normal_load_run();
        do_reset();
        pulse_start();
        tests_run++;
        if (a_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL normal_ready: got %b expected 1", a_ready);
        end
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1;
            load_data  = 16'h1001 + 16'(i);
            load_last  = (i == 4);
            step();
            tests_run++;
            if ({a_we, a_addr, a_wdata} !== {1'b1, 8'(i), 16'h1001 + 16'(i)}) begin
                tests_failed++;
                $display("FAIL normal_write%0d: got we=%b addr=%h data=%h expected we=1 addr=%h data=%h",
                         i, a_we, a_addr, a_wdata, 8'(i), 16'h1001 + 16'(i));
            end
        end
        load_valid = 1'b0; load_last = 1'b0;
        tests_run++;
        if ({a_wc, a_ready} !== {9'd5, 1'b0}) begin
            tests_failed++;
            $display("FAIL normal_count: got wc=%0d ready=%b expected wc=5 ready=0", a_wc, a_ready);
        end
        repeat (4) step();
        tests_run++;
        if ({a_cpu_rst, a_we} !== 2'b10) begin
            tests_failed++;
            $display("FAIL normal_hold: got cpu_rst=%b we=%b expected cpu_rst=1 we=0", a_cpu_rst, a_we);
        end
        step();
        tests_run++;
        if (a_cpu_rst !== 1'b0) begin
            tests_failed++;
            $display("FAIL normal_release: got cpu_rst=%b expected 0", a_cpu_rst);
        end
        cpu_halt = 1'b1; data_mem = 16'hBEEF;
        step();
        cpu_halt = 1'b0;
        tests_run++;
        if ({a_result, a_done, a_to, a_cpu_rst} !== {16'hBEEF, 1'b1, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL normal_halt: got result=%h done=%b to=%b cpu_rst=%b expected BEEF 1 0 1",
                     a_result, a_done, a_to, a_cpu_rst);
        end
    endtask

    task automatic test_overflow_backpressure();
        int writes;
        writes = 0;
        do_reset();
        pulse_start();
        for (int c = 0; c < 12; c++) begin
            load_valid = (c % 2 == 0);
            load_data  = 16'h2000 + 16'(c / 2);
            load_last  = 1'b0;
            step();
            if (b_we === 1'b1) writes++;
            tests_run++;
            if ((c % 2 == 0) && (c / 2 < 4)) begin
                if ({b_we, b_addr, b_wdata} !== {1'b1, 8'(c / 2), 16'h2000 + 16'(c / 2)}) begin
                    tests_failed++;
                    $display("FAIL ovf_write%0d: got we=%b addr=%h data=%h expected we=1 addr=%h",
                             c, b_we, b_addr, b_wdata, 8'(c / 2));
                end
            end else begin
                if (b_we !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL ovf_nowrite%0d: got we=%b expected 0", c, b_we);
                end
            end
            tests_run++;
            if ({b_ready, b_cpu_rst} !== {(c < 6), (c != 11)}) begin
                tests_failed++;
                $display("FAIL ovf_ctrl%0d: got ready=%b cpu_rst=%b expected ready=%b cpu_rst=%b",
                         c, b_ready, b_cpu_rst, (c < 6), (c != 11));
            end
        end
        load_valid = 1'b0;
        tests_run++;
        if ((writes !== 4) || (b_wc !== 9'd4)) begin
            tests_failed++;
            $display("FAIL ovf_total: got writes=%0d wc=%0d expected 4 4", writes, b_wc);
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        data_mem = 16'h5A5A;
        pulse_start();
        load_one_and_run(16'h3001);
        tests_run++;
        if (b_cpu_rst !== 1'b0) begin
            tests_failed++;
            $display("FAIL wdt_run: got cpu_rst=%b expected 0", b_cpu_rst);
        end
        repeat (14) step();
        tests_run++;
        if ({b_to, b_cpu_rst} !== 2'b00) begin
            tests_failed++;
            $display("FAIL wdt_early: got to=%b cpu_rst=%b at R+14 expected 0 0", b_to, b_cpu_rst);
        end
        step();
        tests_run++;
        if ({b_to, b_done, b_result, b_cpu_rst} !== {1'b1, 1'b0, 16'h0, 1'b1}) begin
            tests_failed++;
            $display("FAIL wdt_expire: got to=%b done=%b result=%h cpu_rst=%b expected 1 0 0000 1",
                     b_to, b_done, b_result, b_cpu_rst);
        end
        repeat (3) step();
        tests_run++;
        if ({b_to, b_cpu_rst} !== 2'b11) begin
            tests_failed++;
            $display("FAIL wdt_held: got to=%b cpu_rst=%b expected 1 1", b_to, b_cpu_rst);
        end
    endtask

    // Continues from the TIMEOUT state left by test_watchdog.
    task automatic test_halt_at_expiry();
        pulse_start();
        tests_run++;
        if ({b_to, b_wc, b_ready} !== {1'b0, 9'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL restart_clear: got to=%b wc=%0d ready=%b expected 0 0 1", b_to, b_wc, b_ready);
        end
        load_one_and_run(16'h3002);
        repeat (14) step();
        cpu_halt = 1'b1; data_mem = 16'h1234;
        step();
        cpu_halt = 1'b0;
        tests_run++;
        if ({b_done, b_to, b_result} !== {1'b1, 1'b0, 16'h1234}) begin
            tests_failed++;
            $display("FAIL halt_expiry: got done=%b to=%b result=%h expected 1 0 1234",
                     b_done, b_to, b_result);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        pulse_start();
        load_one_and_run(16'h3003);
        repeat (3) step();
        tests_run++;
        if ({a_cpu_rst, a_wc} !== {1'b0, 9'd1}) begin
            tests_failed++;
            $display("FAIL midrun_pre: got cpu_rst=%b wc=%0d expected 0 1", a_cpu_rst, a_wc);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (a_vec !== reset_vec) begin
            tests_failed++;
            $display("FAIL midrun_async: got %h expected %h", a_vec, reset_vec);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        pulse_start();
        load_valid = 1'b1; load_data = 16'h4001; load_last = 1'b0;
        step();
        tests_run++;
        if ({a_we, a_addr, a_wdata} !== {1'b1, 8'd0, 16'h4001}) begin
            tests_failed++;
            $display("FAIL midrun_w0: got we=%b addr=%h data=%h expected 1 00 4001", a_we, a_addr, a_wdata);
        end
        load_data = 16'h4002; load_last = 1'b1;
        step();
        load_valid = 1'b0; load_last = 1'b0;
        tests_run++;
        if ({a_we, a_addr, a_wdata, a_wc} !== {1'b1, 8'd1, 16'h4002, 9'd2}) begin
            tests_failed++;
            $display("FAIL midrun_w1: got we=%b addr=%h data=%h wc=%0d expected 1 01 4002 2",
                     a_we, a_addr, a_wdata, a_wc);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_vec    = {1'b1, 53'd0};
        test_reset();
        test_normal_load_run();
        test_overflow_backpressure();
        test_watchdog();
        test_halt_at_expiry();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
